// File: rtl/pipe_stall_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl_pkg
// Purpose  : Shared definitions for the pipeline stall/flush controller.
//            Holds the MDU scheduler state encodings and the default
//            multiply/divide latencies.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_stall_ctrl_pkg;

   // MDU scheduler states; kept as plain logic constants so older tools
   // that dislike enum-typed state registers still accept them.
   localparam logic [0:0] MD_IDLE = 1'b0;
   localparam logic [0:0] MD_BUSY = 1'b1;

   // Default busy latencies following a start pulse.
   localparam int unsigned MULT_LAT_DEF = 5;
   localparam int unsigned DIV_LAT_DEF  = 10;

   // Pick the busy latency for an operation that is starting.
   function automatic int unsigned md_lat_sel(
      input logic        is_div,
      input int unsigned mult_lat,
      input int unsigned div_lat
   );
      return is_div ? div_lat : mult_lat;
   endfunction

endpackage : pipe_stall_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_stall_ctrl_md_busy_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : md_busy_sched
// Purpose  : Multiply/divide unit busy scheduler. A start pulse in E loads a
//            down-counter with the operation latency; md_busy is high while
//            the counter runs. Exception requests cancel a start that arrives
//            in the same cycle but never abort an operation already running.
// Revision : 1.0 - initial release
// ============================================================================
module md_busy_sched
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int unsigned MULT_LAT = MULT_LAT_DEF,
   parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
   parameter int unsigned CNT_W    = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic Req,
   input  logic md_start_E,
   input  logic md_is_div_E,
   output logic md_busy
);

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             start_ok;

   // A start is only honoured from idle and only when no exception is
   // being taken; a start while busy cannot legally happen and is dropped.
   assign start_ok = md_start_E & ~Req;

   // Next-state and counter logic for the busy scheduler.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         MD_IDLE: begin
            if (start_ok) begin
               state_nxt = MD_BUSY;
               cnt_nxt   = CNT_W'(md_lat_sel(md_is_div_E, MULT_LAT, DIV_LAT));
            end
         end
         MD_BUSY: begin
            // Leave busy on the edge where the count drops 1 -> 0; a zero
            // count here is unreachable but is treated the same way.
            if (cnt <= CNT_W'(1)) begin
               state_nxt = MD_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = MD_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= MD_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Busy flag; held low while reset is asserted.
   assign md_busy = (state == MD_BUSY) & ~reset;

endmodule : md_busy_sched
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Purpose  : Central stall/flush controller for the five-stage pipeline.
//            Merges the D-stage data-hazard stall, the MDU busy stall and the
//            ERET/EPC hazard into a single stall that freezes PC and F/D and
//            bubbles D/E. An exception request always overrides the stall.
//            Optional macro PIPE_STALL_PERF_EN builds a 32-bit stall-cycle
//            performance counter; without it stall_cycles reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int unsigned MULT_LAT = MULT_LAT_DEF,
   parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
   parameter int unsigned CNT_W    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Req,
   input  logic        hz_stall_D,
   input  logic        md_use_D,
   input  logic        md_start_E,
   input  logic        md_is_div_E,
   input  logic        eret_D,
   input  logic        mtc0_epc_E,
   input  logic        mtc0_epc_M,
   output logic        enable_PC,
   output logic        enable_D,
   output logic        flush_E,
   output logic        md_busy,
   output logic [31:0] stall_cycles
);

   logic st_md;
   logic st_eret;
   logic stall;

   md_busy_sched #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT),
      .CNT_W    (CNT_W)
   ) u_md_busy_sched (
      .clk         (clk),
      .reset       (reset),
      .Req         (Req),
      .md_start_E  (md_start_E),
      .md_is_div_E (md_is_div_E),
      .md_busy     (md_busy)
   );

   // An MDU consumer in D must wait while an op runs, and also in the very
   // cycle the op starts in E (busy is not yet registered then).
   assign st_md   = md_use_D & (md_busy | md_start_E);
   // ERET must not read EPC while an mtc0 to EPC is still in E or M.
   assign st_eret = eret_D & (mtc0_epc_E | mtc0_epc_M);
   // Req wins so the redirect into the handler is never held off; reset
   // forces the pipeline free-running.
   assign stall   = (hz_stall_D | st_md | st_eret) & ~Req & ~reset;

   assign enable_PC = ~stall;
   assign enable_D  = ~stall;
   assign flush_E   = stall;

`ifdef PIPE_STALL_PERF_EN
   logic [31:0] stall_cnt;

   // Count stalled cycles; wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stall) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt;
`else
   assign stall_cycles = '0;
`endif

endmodule : pipe_stall_ctrl
`default_nettype wire

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/flush controller for the five-stage pipeline. It merges the external data-hazard stall, the multiply/divide unit (MDU) busy scheduler and the ERET/EPC hazard into one stall decision. It drives the PC enable, the F/D register enable (`enable_D`) and the D/E bubble flush. The exception request `Req` always overrides stalls, so the flush into the handler is never blocked.

## Interface
- `MULT_LAT`, 5, busy cycles following a mult/multu start
- `DIV_LAT`, 10, busy cycles following a div/divu start
- `CNT_W`, 4, MDU counter width; must hold `DIV_LAT`

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `Req`  in  1  exception/interrupt request from CP0 (M stage)
- `hz_stall_D`  in  1  data-hazard stall from the D-stage hazard unit
- `md_use_D`  in  1  instruction in D uses MDU (mult/div/mfhi/mflo/mthi/mtlo)
- `md_start_E`  in  1  mult/div in E this cycle (one-cycle pulse)
- `md_is_div_E`  in  1  qualifies `md_start_E`: 1 = div, 0 = mult
- `eret_D`  in  1  ERET in D
- `mtc0_epc_E`, `mtc0_epc_M`  in  1 each  mtc0 writing EPC in E / M
- `enable_PC`  out  1  PC register enable
- `enable_D`  out  1  F/D register enable
- `flush_E`  out  1  D/E register inserts a bubble
- `md_busy`  out  1  MDU result not ready
- `stall_cycles`  out  32  stall performance counter (see Configuration)

## Operation
- MDU FSM states: `MD_IDLE`, `MD_BUSY`.
  - `MD_IDLE` -> `MD_BUSY` on `md_start_E & ~Req`.
  - On that transition the counter loads `MULT_LAT`, or `DIV_LAT` when `md_is_div_E=1`.
  - In `MD_BUSY` the counter decrements every cycle.
  - `MD_BUSY` -> `MD_IDLE` at the edge where the counter goes 1 -> 0.
  - `md_busy = (state == MD_BUSY)`.
- `md_start_E` while in `MD_BUSY` cannot occur, because D is stalled. If it is asserted anyway, it is ignored.
- `Req` does not abort an in-flight MDU op; counting continues. `md_start_E` in the same cycle as `Req` is dropped.
- Stall sources, combinational:
  - `st_md = md_use_D & (md_busy | md_start_E)`
  - `st_eret = eret_D & (mtc0_epc_E | mtc0_epc_M)`
  - `stall = (hz_stall_D | st_md | st_eret) & ~Req`
- Outputs:
  - `enable_PC = ~stall`
  - `enable_D = ~stall`
  - `flush_E = stall`
  - `Req` itself does not drive `flush_E`; each pipeline register flushes on `Req` locally.
- While `reset=1`, outputs are forced to `enable_PC=1`, `enable_D=1`, `flush_E=0`, `md_busy=0`.

## Timing
- Reset values: state `MD_IDLE`, counter 0, `md_busy=0`, `stall_cycles=0`.
- The combinational outputs carry no register latency. Only the MDU state and the counter are registered.
- A start in cycle t gives `md_busy=1` for cycles t+1 .. t+LAT.
- A dependent instruction in D stalls for cycles t .. t+LAT, i.e. LAT+1 cycles.
- The first non-stalled cycle is t+LAT+1.
- ERET stalls while the EPC writer sits in E or M: 2 cycles when the mtc0 is in E.
- Mid-operation reset: the next cycle is `MD_IDLE` with counter 0.

## Configuration
- `PIPE_STALL_PERF_EN` defined:
  - `stall_cycles` increments by 1 on every cycle with `stall=1` and `reset=0`.
  - Wraps modulo 2^32.
  - Clears on reset.
- `PIPE_STALL_PERF_EN` undefined: `stall_cycles` is tied to 0 and no counter register is built.

## Structure
- The shared package holds:
  - MDU state encodings `MD_IDLE`/`MD_BUSY`.
  - Default latencies `MULT_LAT_DEF=5`, `DIV_LAT_DEF=10`.
- One sub-module, `md_busy_sched`, contains the FSM and counter and outputs `md_busy`. The top level holds the stall OR and the perf counter.

## Test plan
- Hazard stall: `hz_stall_D=1`, all else 0 -> `enable_PC=0`, `enable_D=0`, `flush_E=1`.
- Mult then MDU use:
  - Stimulus: `md_start_E=1`, `md_is_div_E=0` at cycle 0, with `md_use_D=1` held.
  - Response: stall for cycles 0–5; `md_busy=1` for cycles 1–5; `enable_D=1` at cycle 6.
- Div interrupted: div start at cycle 0, `Req=1` at cycle 3.
  - Cycle 3: `enable_D=1`, `flush_E=0`.
  - `md_busy` stays 1 through cycle 10.
- Start cancelled: `md_start_E=1` and `Req=1` in the same cycle -> `md_busy` stays 0 the next cycle.
- ERET hazard: `eret_D=1` held, `mtc0_epc_E=1` in cycle 0, then `mtc0_epc_M=1` in cycle 1.
  - Stall in cycles 0–1; free in cycle 2.
- Reset mid-div: reset at cycle 4 of a div -> cycle 5 has `md_busy=0`.
  - With `PIPE_STALL_PERF_EN` defined: `stall_cycles=0`.
